// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one registered full-adder cell, LSB-first, with
// valid/ready handshakes on operand load and result retrieval.
// Optional signed-overflow output OVF is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             done_valid,
  input  logic             done_ready,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             busy,
  output logic             OVF
`else
  output logic             busy
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             done_valid_q, done_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_s;
  logic             carry_nxt_s;
  logic [WIDTH-1:0] sum_shift_s;

  // Full-adder cell on the current LSB pair plus the stored carry
  always_comb begin
    bit_s       = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_nxt_s = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    sum_shift_s = sum_sr_q >> 1;
    sum_shift_s[WIDTH-1] = bit_s;
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    sum_sr_d     = sum_sr_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    s_d          = s_q;
    cout_d       = cout_q;
    done_valid_d = done_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sr_d  = A;
          b_sr_d  = B;
          carry_d = Cin;
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift_s;
        carry_d  = carry_nxt_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Last bit: the MSB pair is in bit 0, so carry_q is the carry into the MSB
          state_d      = DONE;
          s_d          = sum_shift_s;
          cout_d       = carry_nxt_s;
          done_valid_d = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d        = carry_q ^ carry_nxt_s;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d      = IDLE;
          done_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d      = IDLE;
        done_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sr_q       <= {WIDTH{1'b0}};
      b_sr_q       <= {WIDTH{1'b0}};
      sum_sr_q     <= {WIDTH{1'b0}};
      carry_q      <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      s_q          <= {WIDTH{1'b0}};
      cout_q       <= 1'b0;
      done_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      sum_sr_q     <= sum_sr_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      cout_q       <= cout_d;
      done_valid_q <= done_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == SHIFT) || (state_q == DONE);
  assign S           = s_q;
  assign Cout        = cout_q;
  assign done_valid  = done_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign OVF         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances)
// against an arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic       Cin = 1'b0;
  logic [7:0] S;
  logic       Cout;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic       busy;

  logic       sv1 = 1'b0;
  logic       sr1;
  logic [0:0] a1 = 1'b0;
  logic [0:0] b1 = 1'b0;
  logic       c1 = 1'b0;
  logic [0:0] s1;
  logic       co1;
  logic       dv1;
  logic       dr1 = 1'b0;
  logic       busy1;

  int checks = 0;
  int errors = 0;

`ifdef SERIAL_ADDER_OVF_EN
  logic OVF;
  logic ovf1;
`endif

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout), .done_valid(done_valid),
    .done_ready(done_ready),
`ifdef SERIAL_ADDER_OVF_EN
    .busy(busy), .OVF(OVF)
`else
    .busy(busy)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .A(a1), .B(b1), .Cin(c1), .S(s1), .Cout(co1), .done_valid(dv1),
    .done_ready(dr1),
`ifdef SERIAL_ADDER_OVF_EN
    .busy(busy1), .OVF(ovf1)
`else
    .busy(busy1)
`endif
  );

  always #5 clk = ~clk;

  // Two's-complement overflow from signed arithmetic
  function automatic logic ovf_ref(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int sa, sb, sum;
    sa  = a[7] ? int'(a) - 256 : int'(a);
    sb  = b[7] ? int'(b) - 256 : int'(b);
    sum = sa + sb + int'(ci);
    return (sum > 127) || (sum < -128);
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if ({S, Cout, done_valid, busy, start_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got S=%h Cout=%b dv=%b busy=%b sr=%b, want 00 0 0 0 1",
               S, Cout, done_valid, busy, start_ready);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (OVF !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", OVF);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci, input string name);
    logic [8:0] exp;
    int n;
    exp = 9'(a) + 9'(b) + 9'(ci);
    n = 0;
    while (start_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: start_ready=%b want 1", name, start_ready);
    end
    A = a; B = b; Cin = ci; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (i < 8 && {done_valid, start_ready, busy} !== 3'b001) begin
        errors++;
        $display("FAIL %s_shift_cyc%0d: dv/sr/busy=%b want 001", name, i, {done_valid, start_ready, busy});
      end else if (i == 8 && {done_valid, start_ready, busy} !== 3'b101) begin
        errors++;
        $display("FAIL %s_done_latency: dv/sr/busy=%b want 101", name, {done_valid, start_ready, busy});
      end
    end
    checks++;
    if ({Cout, S} !== exp) begin
      errors++;
      $display("FAIL %s_sum: got Cout=%b S=%h want Cout=%b S=%h", name, Cout, S, exp[8], exp[7:0]);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (OVF !== ovf_ref(a, b, ci)) begin
      errors++;
      $display("FAIL %s_ovf: got %b want %b", name, OVF, ovf_ref(a, b, ci));
    end
`endif
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    checks++;
    if ({done_valid, start_ready, busy, Cout, S} !== {3'b010, exp}) begin
      errors++;
      $display("FAIL %s_release: dv/sr/busy=%b Cout=%b S=%h want 010 %b %h",
               name, {done_valid, start_ready, busy}, Cout, S, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_directed();
    do_op(8'h35, 8'h4A, 1'b0, "add35_4a");
    do_op(8'hFF, 8'h01, 1'b0, "addff_01");
    do_op(8'hFF, 8'hFF, 1'b1, "addff_ff_c");
    do_op(8'h7F, 8'h01, 1'b0, "ovf7f_01");
    do_op(8'h80, 8'h80, 1'b0, "ovf80_80");
    do_op(8'h05, 8'h03, 1'b0, "ovf05_03");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), "rand");
  endtask

  task automatic test_backpressure();
    logic [8:0] exp;
    int n;
    exp = 9'(8'hC3) + 9'(8'h5A) + 9'(1'b1);
    A = 8'hC3; B = 8'h5A; Cin = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n = 0;
    while (done_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({done_valid, start_ready, Cout, S} !== {2'b10, exp}) begin
        errors++;
        $display("FAIL bp_hold_%0d: dv/sr=%b Cout=%b S=%h want 10 %b %h",
                 i, {done_valid, start_ready}, Cout, S, exp[8], exp[7:0]);
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    checks++;
    if ({done_valid, start_ready, busy, Cout, S} !== {3'b010, exp}) begin
      errors++;
      $display("FAIL bp_release: dv/sr/busy=%b Cout=%b S=%h want 010 %b %h",
               {done_valid, start_ready, busy}, Cout, S, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_reset_midop();
    int seen_dv;
    A = 8'hAA; B = 8'h77; Cin = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({S, Cout, done_valid, busy, start_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midop_reset: got S=%h Cout=%b dv=%b busy=%b sr=%b, want 00 0 0 0 1",
               S, Cout, done_valid, busy, start_ready);
    end
    seen_dv = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_valid !== 1'b0) seen_dv++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_valid !== 1'b0) seen_dv++;
    end
    checks++;
    if (seen_dv != 0) begin
      errors++;
      $display("FAIL midop_no_done: done_valid high %0d samples, want 0", seen_dv);
    end
    do_op(8'h10, 8'h20, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [8:0] q[$];
    logic [8:0] e;
    int cyc, last, got;
    cyc = 0; last = -1; got = 0;
    done_ready = 1'b1; start_valid = 1'b1;
    A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
    if (start_ready) q.push_back(9'(A) + 9'(B) + 9'(Cin));
    while (got < 6 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done_valid) begin
        checks++;
        e = (q.size() > 0) ? q.pop_front() : 9'h1FF;
        if ({Cout, S} !== e) begin
          errors++;
          $display("FAIL b2b8_sum: got Cout=%b S=%h want %h", Cout, S, e);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 10) begin
            errors++;
            $display("FAIL b2b8_period: got %0d cycles want 10", cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      if (got < 6) begin
        A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
        if (start_ready) q.push_back(9'(A) + 9'(B) + 9'(Cin));
      end
    end
    start_valid = 1'b0;
    checks++;
    if (got != 6 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b8_count: got %0d results, %0d pending, want 6 and 0", got, q.size());
    end
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic test_back_to_back_w1();
    logic [1:0] q[$];
    logic [1:0] e;
    int cyc, last, got;
    cyc = 0; last = -1; got = 0;
    dr1 = 1'b1; sv1 = 1'b1;
    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
    if (sr1) q.push_back(2'(a1) + 2'(b1) + 2'(c1));
    while (got < 8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (dv1) begin
        checks++;
        e = (q.size() > 0) ? q.pop_front() : 2'bxx;
        if ({co1, s1} !== e) begin
          errors++;
          $display("FAIL b2b1_sum: got Cout=%b S=%b want %b", co1, s1, e);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("FAIL b2b1_period: got %0d cycles want 3", cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      if (got < 8) begin
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        if (sr1) q.push_back(2'(a1) + 2'(b1) + 2'(c1));
      end
    end
    sv1 = 1'b0;
    checks++;
    if (got != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b1_count: got %0d results, %0d pending, want 8 and 0", got, q.size());
    end
    @(posedge clk); #1;
    dr1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_back_to_back_w1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
